// File: rtl/trace_pkg.sv
// Shared types, default configuration and helper functions for the
// register-write trace buffer and its multi-push FIFO.
package trace_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREG_DEF   = 32;
    localparam int NPORTS_DEF = 2;
    localparam int DEPTH_DEF  = 16;
    localparam int TS_W_DEF   = 16;
    localparam int DROP_W_DEF = 16;

    localparam int AW_DEF     = $clog2(NREG_DEF);
    localparam int PORT_W_DEF = (NPORTS_DEF > 1) ? $clog2(NPORTS_DEF) : 1;
    localparam int MAX_MASK_W = 64;

    typedef struct packed {
        logic [PORT_W_DEF-1:0] port;
        logic [AW_DEF-1:0]     addr;
        logic [XLEN_DEF-1:0]   data;
        logic [TS_W_DEF-1:0]   ts;
        logic                  irq;
    } trace_entry_t;

    // Number of set bits in a port mask, clamped to the number of ports.
    function automatic int unsigned popcount_sat(input logic [MAX_MASK_W-1:0] mask,
                                                 input int unsigned cap);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_MASK_W; i++) begin
            n += mask[i] ? 1 : 0;
        end
        return (n > cap) ? cap : n;
    endfunction

    // Adds inc to cur, clamping at the all-ones value of a width-bit counter.
    function automatic logic [63:0] sat_add(input logic [63:0] cur,
                                            input logic [63:0] inc,
                                            input int unsigned width);
        logic [63:0] max_v;
        logic [63:0] sum;
        max_v = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        sum   = cur + inc;
        if ((sum > max_v) || (sum < cur)) begin
            sum = max_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/trace_fifo_mp.sv
// Circular buffer accepting up to NPORTS pushes and one pop per cycle, with an
// optional overwrite-oldest policy when the pushes exceed the free space.
module trace_fifo_mp
    import trace_pkg::*;
#(
    parameter  int W      = 8,
    parameter  int DEPTH  = DEPTH_DEF,
    parameter  int NPORTS = NPORTS_DEF,
    localparam int CW     = $clog2(DEPTH) + 1,
    localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NW     = $clog2(NPORTS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              overwrite,
    input  logic [NW-1:0]     push_n,
    input  logic [NPORTS*W-1:0] push_data,
    input  logic              pop,
    output logic              head_valid,
    output logic [W-1:0]      head_data,
    output logic [CW-1:0]     count,
    output logic [NW-1:0]     acc_n,
    output logic [NW-1:0]     lost_n
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_idx [NPORTS];
    logic          pop_eff;
    int            pop_i, cnt_i, push_i, free_i, acc_i, excess_i;

    // Space check sees the slot freed by a same-cycle pop; in overwrite mode
    // the excess advances the head past the oldest entries.
    always_comb begin
        pop_eff  = pop && (count_q != '0);
        pop_i    = pop_eff ? 1 : 0;
        cnt_i    = int'(count_q);
        push_i   = int'(push_n);
        free_i   = DEPTH - cnt_i + pop_i;
        acc_i    = push_i;
        excess_i = 0;
        if (push_i > free_i) begin
            if (overwrite) begin
                excess_i = push_i - free_i;
            end else begin
                acc_i = free_i;
            end
        end
        acc_n   = NW'(acc_i);
        lost_n  = NW'(push_i - acc_i + excess_i);
        head_d  = PW'((int'(head_q) + pop_i + excess_i) % DEPTH);
        count_d = CW'(cnt_i - pop_i + acc_i - excess_i);
        for (int k = 0; k < NPORTS; k++) begin
            wr_idx[k] = PW'((int'(head_q) + cnt_i + k) % DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NPORTS; k++) begin
                if (k < acc_i) begin
                    mem_q[wr_idx[k]] <= push_data[k*W +: W];
                end
            end
        end
    end

    assign head_valid = (count_q != '0);
    assign head_data  = head_valid ? mem_q[head_q] : '0;
    assign count      = count_q;

endmodule

// File: rtl/regwrite_trace_buffer.sv
// Captures qualified register-file writes from several writeback ports into a
// timestamped trace FIFO and keeps a shadow copy of the architectural registers.
module regwrite_trace_buffer
    import trace_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREG   = NREG_DEF,
    parameter  int NPORTS = NPORTS_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    parameter  int TS_W   = TS_W_DEF,
    parameter  int DROP_W = DROP_W_DEF,
    localparam int AW     = $clog2(NREG),
    localparam int PORT_W = (NPORTS > 1) ? $clog2(NPORTS) : 1,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NPORTS-1:0]      wr_en,
    input  logic [NPORTS*AW-1:0]   wr_addr,
    input  logic [NPORTS*XLEN-1:0] wr_data,
    input  logic                   irq,
    input  logic                   mode_wrap,
    input  logic                   freeze,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [PORT_W-1:0]      rd_port,
    output logic [AW-1:0]          rd_addr,
    output logic [XLEN-1:0]        rd_data,
    output logic [TS_W-1:0]        rd_ts,
    output logic                   rd_irq,
    output logic [CW-1:0]          count,
    output logic [DROP_W-1:0]      dropped,
    output logic                   overflow,
    input  logic [AW-1:0]          sh_addr,
    output logic [XLEN-1:0]        sh_data
);

    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic [AW-1:0]     addr;
        logic [XLEN-1:0]   data;
        logic [TS_W-1:0]   ts;
        logic              irq;
    } entry_t;

    localparam int EW = $bits(entry_t);
    localparam int NW = $clog2(NPORTS + 1);

    logic [TS_W-1:0]   ts_q, ts_d;
    logic              irq_q, irq_d;
    logic              irq_pending_q, irq_pending_d;
    logic [DROP_W-1:0] dropped_q, dropped_d;
    logic              overflow_q, overflow_d;
    logic [XLEN-1:0]   shadow_q [NREG];
    logic [XLEN-1:0]   shadow_d [NREG];

    logic [NPORTS-1:0]    qual, push_mask;
    logic [NW-1:0]        push_n, acc_n, lost_n;
    logic [NPORTS*EW-1:0] push_data;
    logic                 irq_mark;
    logic                 pop;
    logic                 head_valid;
    logic [EW-1:0]        head_raw;
    entry_t               head;
    logic [CW-1:0]        fifo_count;

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            qual[p] = wr_en[p] && (wr_addr[p*AW +: AW] != '0);
        end
        push_mask = freeze ? '0 : qual;
        push_n    = NW'(popcount_sat(MAX_MASK_W'(push_mask), NPORTS));
        irq_mark  = irq_pending_q || (irq && !irq_q);
    end

    // Pack qualified events densely in ascending port order; only the first
    // packed slot can carry the irq mark.
    always_comb begin : compact_blk
        int     rank;
        entry_t ent;
        push_data = '0;
        rank      = 0;
        for (int p = 0; p < NPORTS; p++) begin
            ent      = '0;
            ent.port = PORT_W'(p);
            ent.addr = wr_addr[p*AW +: AW];
            ent.data = wr_data[p*XLEN +: XLEN];
            ent.ts   = ts_q;
            ent.irq  = irq_mark && (rank == 0);
            if (push_mask[p]) begin
                push_data[rank*EW +: EW] = ent;
                rank = rank + 1;
            end
        end
    end

    assign pop = head_valid && rd_ready;

    trace_fifo_mp #(
        .W      (EW),
        .DEPTH  (DEPTH),
        .NPORTS (NPORTS)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .overwrite  (mode_wrap),
        .push_n     (push_n),
        .push_data  (push_data),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head_raw),
        .count      (fifo_count),
        .acc_n      (acc_n),
        .lost_n     (lost_n)
    );

    // Pending irq survives freeze and a full FIFO until some entry lands.
    always_comb begin
        ts_d          = ts_q + TS_W'(1);
        irq_d         = irq;
        irq_pending_d = (acc_n != '0) ? 1'b0 : irq_mark;
        dropped_d     = DROP_W'(sat_add(64'(dropped_q), 64'(lost_n), DROP_W));
        overflow_d    = overflow_q || (lost_n != '0);
    end

    // Later ports overwrite earlier ones when several target the same register.
    always_comb begin
        shadow_d = shadow_q;
        for (int p = 0; p < NPORTS; p++) begin
            if (qual[p]) begin
                shadow_d[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ts_q          <= '0;
            irq_q         <= 1'b0;
            irq_pending_q <= 1'b0;
            dropped_q     <= '0;
            overflow_q    <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            ts_q          <= ts_d;
            irq_q         <= irq_d;
            irq_pending_q <= irq_pending_d;
            dropped_q     <= dropped_d;
            overflow_q    <= overflow_d;
            for (int i = 0; i < NREG; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign head     = head_raw;
    assign rd_valid = head_valid;
    assign rd_port  = head.port;
    assign rd_addr  = head.addr;
    assign rd_data  = head.data;
    assign rd_ts    = head.ts;
    assign rd_irq   = head.irq;
    assign count    = fifo_count;
    assign dropped  = dropped_q;
    assign overflow = overflow_q;
    assign sh_data  = (sh_addr == '0) ? '0 : shadow_q[sh_addr];

endmodule

// File: tb/tb_regwrite_trace_buffer.sv
// Directed bench for regwrite_trace_buffer: a queue-based reference model is
// compared against the DUT every cycle, plus hand-computed spot checks.
module tb_regwrite_trace_buffer;

    localparam int AW     = 5;
    localparam int DEPTH  = 16;
    localparam int NPORTS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        irq, mode_wrap, freeze, rd_ready;
    logic        rd_valid;
    logic [0:0]  rd_port;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [15:0] rd_ts;
    logic        rd_irq;
    logic [4:0]  count;
    logic [15:0] dropped;
    logic        overflow;
    logic [4:0]  sh_addr;
    logic [31:0] sh_data;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    regwrite_trace_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .irq       (irq),
        .mode_wrap (mode_wrap),
        .freeze    (freeze),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_port   (rd_port),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_ts     (rd_ts),
        .rd_irq    (rd_irq),
        .count     (count),
        .dropped   (dropped),
        .overflow  (overflow),
        .sh_addr   (sh_addr),
        .sh_data   (sh_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        int          addr;
        logic [31:0] data;
        int          ts;
        bit          irq;
    } ent_t;

    ent_t        mq[$];
    ent_t        m_ent;
    logic [31:0] m_shadow [32];
    int          m_ts = 0;
    bit          m_irq_prev = 1'b0;
    bit          m_pending = 1'b0;
    int          m_dropped = 0;
    bit          m_overflow = 1'b0;
    logic [4:0]  m_a;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelDrop();
        m_dropped  = (m_dropped == 65535) ? 65535 : m_dropped + 1;
        m_overflow = 1'b1;
    endtask

    // Reference model: pop first, then each qualified event in port order.
    initial forever begin
        @(posedge clk);
        if (!reset) begin
            mq.delete();
            for (int i = 0; i < 32; i++) m_shadow[i] = '0;
            m_ts       = 0;
            m_irq_prev = 1'b0;
            m_pending  = 1'b0;
            m_dropped  = 0;
            m_overflow = 1'b0;
        end else begin
            if (rd_ready && mq.size() != 0) void'(mq.pop_front());
            m_pending = m_pending || (irq && !m_irq_prev);
            for (int p = 0; p < NPORTS; p++) begin
                m_a = wr_addr[p*AW +: AW];
                if (wr_en[p] && m_a != 5'd0) begin
                    m_shadow[m_a] = wr_data[p*32 +: 32];
                    if (!freeze) begin
                        m_ent.port = p;
                        m_ent.addr = int'(m_a);
                        m_ent.data = wr_data[p*32 +: 32];
                        m_ent.ts   = m_ts;
                        m_ent.irq  = 1'b0;
                        if (mq.size() < DEPTH || mode_wrap) begin
                            if (mq.size() == DEPTH) begin
                                void'(mq.pop_front());
                                modelDrop();
                            end
                            if (m_pending) begin
                                m_ent.irq = 1'b1;
                                m_pending = 1'b0;
                            end
                            mq.push_back(m_ent);
                        end else begin
                            modelDrop();
                        end
                    end
                end
            end
            m_ts       = (m_ts + 1) % 65536;
            m_irq_prev = irq;
        end
    end

    initial forever begin
        @(negedge clk);
        if (check_en) begin
            checkOutput("rd_valid", 64'(rd_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                checkOutput("rd_port", 64'(rd_port), 64'(mq[0].port));
                checkOutput("rd_addr", 64'(rd_addr), 64'(mq[0].addr));
                checkOutput("rd_data", 64'(rd_data), 64'(mq[0].data));
                checkOutput("rd_ts", 64'(rd_ts), 64'(mq[0].ts));
                checkOutput("rd_irq", 64'(rd_irq), 64'(mq[0].irq));
            end else begin
                checkOutput("rd_idle", 64'({rd_port, rd_addr, rd_data, rd_ts, rd_irq}), 64'(0));
            end
            checkOutput("count", 64'(count), 64'(mq.size()));
            checkOutput("dropped", 64'(dropped), 64'(m_dropped));
            checkOutput("overflow", 64'(overflow), 64'(m_overflow));
            checkOutput("sh_data", 64'(sh_data), (sh_addr == 5'd0) ? 64'(0) : 64'(m_shadow[sh_addr]));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [1:0] en, input logic [4:0] a1, input logic [4:0] a0,
                                 input logic [31:0] d1, input logic [31:0] d0);
        wr_en   = en;
        wr_addr = {a1, a0};
        wr_data = {d1, d0};
        step();
        wr_en = 2'b00;
    endtask

    task automatic resetPulse();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
        irq = 1'b0; mode_wrap = 1'b0; freeze = 1'b0; rd_ready = 1'b0; sh_addr = 5'd5;
        step();
        step();
        check_en = 1'b1;
        checkOutput("reset_count", 64'(count), 64'(0));
        checkOutput("reset_valid", 64'(rd_valid), 64'(0));
        checkOutput("reset_dropped", 64'(dropped), 64'(0));
        reset = 1'b1;

        // Single capture at ts=7
        repeat (7) step();
        applyStimulus(2'b01, 5'd0, 5'd5, 32'd0, 32'hDEADBEEF);
        checkOutput("t1_valid", 64'(rd_valid), 64'(1));
        checkOutput("t1_port", 64'(rd_port), 64'(0));
        checkOutput("t1_addr", 64'(rd_addr), 64'(5));
        checkOutput("t1_data", 64'(rd_data), 64'h0000_0000_DEAD_BEEF);
        checkOutput("t1_ts", 64'(rd_ts), 64'(7));
        checkOutput("t1_shadow", 64'(sh_data), 64'h0000_0000_DEAD_BEEF);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;

        // Two ports, same register
        sh_addr = 5'd3;
        applyStimulus(2'b11, 5'd3, 5'd3, 32'd2, 32'd1);
        checkOutput("t2_count", 64'(count), 64'(2));
        checkOutput("t2_first_port", 64'(rd_port), 64'(0));
        checkOutput("t2_first_data", 64'(rd_data), 64'(1));
        checkOutput("t2_shadow", 64'(sh_data), 64'(2));
        rd_ready = 1'b1;
        step();
        checkOutput("t2_second_port", 64'(rd_port), 64'(1));
        checkOutput("t2_second_data", 64'(rd_data), 64'(2));
        step();
        rd_ready = 1'b0;
        checkOutput("t2_empty", 64'(count), 64'(0));

        // Writes to x0 are ignored
        sh_addr = 5'd0;
        applyStimulus(2'b01, 5'd0, 5'd0, 32'd0, 32'hFFFF_FFFF);
        checkOutput("t3_count", 64'(count), 64'(0));
        checkOutput("t3_shadow", 64'(sh_data), 64'(0));
        checkOutput("t3_dropped", 64'(dropped), 64'(0));

        // Stop mode overflow
        for (int i = 1; i <= 18; i++) applyStimulus(2'b01, 5'd0, 5'd9, 32'd0, 32'(i));
        checkOutput("t4_count", 64'(count), 64'(16));
        checkOutput("t4_dropped", 64'(dropped), 64'(2));
        checkOutput("t4_overflow", 64'(overflow), 64'(1));
        checkOutput("t4_head", 64'(rd_data), 64'(1));
        rd_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            checkOutput("t4_drain", 64'(rd_data), 64'(k));
            step();
        end
        rd_ready = 1'b0;
        checkOutput("t4_drained", 64'(count), 64'(0));

        // Wrap mode overflow
        resetPulse();
        mode_wrap = 1'b1;
        step();
        checkOutput("t5_dropped_clr", 64'(dropped), 64'(0));
        checkOutput("t5_overflow_clr", 64'(overflow), 64'(0));
        for (int i = 1; i <= 18; i++) applyStimulus(2'b01, 5'd0, 5'd9, 32'd0, 32'(i));
        checkOutput("t5_count", 64'(count), 64'(16));
        checkOutput("t5_dropped", 64'(dropped), 64'(2));
        checkOutput("t5_overflow", 64'(overflow), 64'(1));
        checkOutput("t5_head", 64'(rd_data), 64'(3));
        rd_ready = 1'b1;
        for (int k = 3; k <= 18; k++) begin
            checkOutput("t5_drain", 64'(rd_data), 64'(k));
            step();
        end
        rd_ready = 1'b0;

        // Dual pushes against the last free slot, with and without a pop
        mode_wrap = 1'b0;
        step();
        for (int i = 1; i <= 15; i++) applyStimulus(2'b01, 5'd0, 5'd12, 32'd0, 32'(100 + i));
        applyStimulus(2'b11, 5'd13, 5'd12, 32'd201, 32'd200);
        checkOutput("t6_stop_count", 64'(count), 64'(16));
        checkOutput("t6_stop_dropped", 64'(dropped), 64'(3));
        rd_ready = 1'b1;
        applyStimulus(2'b11, 5'd13, 5'd12, 32'd211, 32'd210);
        rd_ready = 1'b0;
        checkOutput("t6_pop_dropped", 64'(dropped), 64'(4));
        mode_wrap = 1'b1;
        step();
        rd_ready = 1'b1;
        applyStimulus(2'b11, 5'd13, 5'd12, 32'd221, 32'd220);
        rd_ready = 1'b0;
        checkOutput("t6_wrap_count", 64'(count), 64'(16));
        checkOutput("t6_wrap_dropped", 64'(dropped), 64'(5));
        checkOutput("t6_wrap_head", 64'(rd_data), 64'(104));

        // irq during freeze, then capture resumes
        resetPulse();
        mode_wrap = 1'b0;
        freeze = 1'b1;
        irq = 1'b1;
        step();
        irq = 1'b0;
        sh_addr = 5'd9;
        applyStimulus(2'b01, 5'd0, 5'd9, 32'd0, 32'h99);
        checkOutput("t7_frozen_count", 64'(count), 64'(0));
        checkOutput("t7_frozen_shadow", 64'(sh_data), 64'h99);
        step();
        freeze = 1'b0;
        applyStimulus(2'b01, 5'd0, 5'd7, 32'd0, 32'h77);
        applyStimulus(2'b01, 5'd0, 5'd8, 32'd0, 32'h88);
        checkOutput("t7_irq_addr", 64'(rd_addr), 64'(7));
        checkOutput("t7_irq_mark", 64'(rd_irq), 64'(1));
        irq = 1'b1;
        applyStimulus(2'b11, 5'd11, 5'd10, 32'hB1, 32'hA0);
        irq = 1'b0;
        rd_ready = 1'b1;
        step();
        checkOutput("t7_next_addr", 64'(rd_addr), 64'(8));
        checkOutput("t7_next_irq", 64'(rd_irq), 64'(0));
        step();
        checkOutput("t7_dual_low_irq", 64'(rd_irq), 64'(1));
        step();
        checkOutput("t7_dual_high_addr", 64'(rd_addr), 64'(11));
        checkOutput("t7_dual_high_irq", 64'(rd_irq), 64'(0));
        step();
        rd_ready = 1'b0;

        // Reset mid-operation
        for (int i = 1; i <= 5; i++) applyStimulus(2'b01, 5'd0, 5'd7, 32'd0, 32'(i));
        checkOutput("t8_queued", 64'(count), 64'(5));
        sh_addr = 5'd7;
        reset = 1'b0;
        step();
        checkOutput("t8_count", 64'(count), 64'(0));
        checkOutput("t8_valid", 64'(rd_valid), 64'(0));
        checkOutput("t8_dropped", 64'(dropped), 64'(0));
        checkOutput("t8_shadow", 64'(sh_data), 64'(0));
        reset = 1'b1;
        step();
        step();

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
